// File: rtl/tcam_pkg.sv
// Shared constants and types for the TCAM rule programming path.
// Holds the default geometry, the op encoding and the writer state encoding.
package tcam_pkg;

  function automatic int log2_res(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  localparam int D_RULE_LEN  = 32;
  localparam int D_MAX_RULE  = 64;
  localparam int D_CHUNK_W   = 4;
  localparam int D_NUM_CHUNK = D_RULE_LEN / D_CHUNK_W;
  localparam int D_IDX_W     = log2_res(D_MAX_RULE);

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tcam_rule_writer_if.sv
// Rule update request channel (valid/ready) into the TCAM rule writer.
// The master side is the control plane; the slave side is the writer.
interface tcam_rule_writer_if
  import tcam_pkg::*;
#(
  parameter int RULE_LEN = D_RULE_LEN,
  parameter int MAX_RULE = D_MAX_RULE
);
  localparam int IDX_W = log2_res(MAX_RULE);

  logic                req_valid;
  logic                req_ready;
  logic                req_op;
  logic [IDX_W-1:0]    req_rule_idx;
  logic [RULE_LEN-1:0] req_value;
  logic [RULE_LEN-1:0] req_mask;

  modport master (
    output req_valid,
    output req_op,
    output req_rule_idx,
    output req_value,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_rule_idx,
    input  req_value,
    input  req_mask,
    output req_ready
  );

endinterface

// File: rtl/tcam_chunk_bitgen.sv
// One LUTRAM data bit for one chunk: set when the address matches the
// rule slice on every cared-for bit, always clear for a delete.
module tcam_chunk_bitgen
  import tcam_pkg::*;
#(
  parameter int CHUNK_W = D_CHUNK_W
) (
  input  logic [CHUNK_W-1:0] addr,
  input  logic [CHUNK_W-1:0] value,
  input  logic [CHUNK_W-1:0] mask,
  input  logic               op,
  output logic               hit
);

  assign hit = (op == OP_WRITE) &&
               (((addr ^ value) & mask) == '0);

endmodule

// File: rtl/tcam_rule_writer.sv
// Expands one rule update into a full sweep of chunk RAM writes and
// maintains the per-slot valid vector seen by the priority encoder.
module tcam_rule_writer
  import tcam_pkg::*;
#(
  parameter int RULE_LEN = D_RULE_LEN,
  parameter int MAX_RULE = D_MAX_RULE,
  parameter int CHUNK_W  = D_CHUNK_W
) (
  input  logic                 clk,
  input  logic                 rst,
  tcam_rule_writer_if.slave    req_if,
  output logic                 wr_en,
  output logic [CHUNK_W-1:0]   wr_addr,
  output logic [log2_res(MAX_RULE)-1:0] wr_rule,
  output logic [RULE_LEN/CHUNK_W-1:0]   wr_bits,
  output logic                 search_stall,
  output logic [MAX_RULE-1:0]  rule_valid,
  output logic                 done,
  output logic                 err
);

  localparam int NUM_CHUNK = RULE_LEN / CHUNK_W;
  localparam int IDX_W     = log2_res(MAX_RULE);

  localparam logic [CHUNK_W-1:0] ADDR_LAST = '1;
  localparam logic [IDX_W:0] MAX_V = (IDX_W+1)'(MAX_RULE);

  state_t              state;
  logic                op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [RULE_LEN-1:0] value_q;
  logic [RULE_LEN-1:0] mask_q;

  logic [CHUNK_W-1:0]   nxt_addr;
  logic                 op_sel;
  logic [RULE_LEN-1:0]  value_sel;
  logic [RULE_LEN-1:0]  mask_sel;
  logic [NUM_CHUNK-1:0] bits;
  logic                 accept;
  logic                 oor;

  assign accept = req_if.req_valid && req_if.req_ready;
  assign oor    = {1'b0, req_if.req_rule_idx} >= MAX_V;

  // Bits are computed one address ahead so wr_bits can be registered.
  always_comb begin
    nxt_addr  = wr_addr + 1'b1;
    op_sel    = op_q;
    value_sel = value_q;
    mask_sel  = mask_q;
    if (state == ST_IDLE) begin
      nxt_addr  = '0;
      op_sel    = req_if.req_op;
      value_sel = req_if.req_value;
      mask_sel  = req_if.req_mask;
    end
  end

  for (genvar c = 0; c < NUM_CHUNK; c++) begin : g_chunk
    tcam_chunk_bitgen #(
      .CHUNK_W (CHUNK_W)
    ) u_bitgen (
      .addr  (nxt_addr),
      .value (value_sel[c*CHUNK_W +: CHUNK_W]),
      .mask  (mask_sel[c*CHUNK_W +: CHUNK_W]),
      .op    (op_sel),
      .hit   (bits[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_WRITE;
      idx_q        <= '0;
      value_q      <= '0;
      mask_q       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_rule      <= '0;
      wr_bits      <= '0;
      search_stall <= 1'b0;
      rule_valid   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      req_if.req_ready <= 1'b1;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            op_q         <= req_if.req_op;
            idx_q        <= req_if.req_rule_idx;
            value_q      <= req_if.req_value;
            mask_q       <= req_if.req_mask;
            search_stall <= 1'b1;
            req_if.req_ready <= 1'b0;
            if (oor) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              wr_en   <= 1'b1;
              wr_addr <= nxt_addr;
              wr_rule <= req_if.req_rule_idx;
              wr_bits <= bits;
            end
          end
        end
        (state == ST_WRITE): begin
          if (wr_addr == ADDR_LAST) begin
            state   <= ST_DONE;
            wr_en   <= 1'b0;
            wr_bits <= '0;
            done    <= 1'b1;
            rule_valid[idx_q] <= (op_q == OP_WRITE);
          end else begin
            wr_addr <= nxt_addr;
            wr_bits <= bits;
          end
        end
        (state == ST_DONE): begin
          state        <= ST_IDLE;
          done         <= 1'b0;
          err          <= 1'b0;
          search_stall <= 1'b0;
          req_if.req_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Directed bench for tcam_rule_writer with MAX_RULE=48.
// Expected write patterns are hand-derived tables.
module tb_tcam_rule_writer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [5:0]  wr_rule;
  logic [7:0]  wr_bits;
  logic        search_stall;
  logic [47:0] rule_valid;
  logic        done;
  logic        err;

  int checks;
  int errors;

  tcam_rule_writer_if #(
    .RULE_LEN (32),
    .MAX_RULE (48)
  ) req_if ();

  tcam_rule_writer #(
    .RULE_LEN (32),
    .MAX_RULE (48),
    .CHUNK_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_if       (req_if),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_rule      (wr_rule),
    .wr_bits      (wr_bits),
    .search_stall (search_stall),
    .rule_valid   (rule_valid),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: 0xC0A80100/0xFFFFFF00, 1: delete, 2: full wildcard
  function automatic logic [7:0] exp_bits(input int mode,
                                          input int a);
    if (mode == 1) return 8'h00;
    if (mode == 2) return 8'hFF;
    case (a)
      0:  return 8'h4B;
      1:  return 8'h07;
      8:  return 8'h13;
      10: return 8'h23;
      12: return 8'h83;
      default: return 8'h03;
    endcase
  endfunction

  task automatic run_update(input logic op,
                            input logic [5:0] idx,
                            input logic [31:0] val,
                            input logic [31:0] msk,
                            input int mode,
                            input logic [47:0] exp_rv);
    @(negedge clk);
    check("pre_ready", req_if.req_ready, 1);
    req_if.req_valid    = 1'b1;
    req_if.req_op       = op;
    req_if.req_rule_idx = idx;
    req_if.req_value    = val;
    req_if.req_mask     = msk;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("wr_en", wr_en, 1);
      check("wr_addr", wr_addr, k);
      check("wr_rule", wr_rule, idx);
      check("wr_bits", wr_bits, exp_bits(mode, k));
      check("stall_w", search_stall, 1);
      check("ready_w", req_if.req_ready, 0);
      check("done_w", done, 0);
      @(negedge clk);
    end
    check("done", done, 1);
    check("err", err, 0);
    check("wr_en_d", wr_en, 0);
    check("stall_d", search_stall, 1);
    check("ready_d", req_if.req_ready, 0);
    check("rule_valid", rule_valid, exp_rv);
    @(negedge clk);
    check("done_off", done, 0);
    check("ready_i", req_if.req_ready, 1);
    check("stall_i", search_stall, 0);
  endtask

  initial begin
    int seen_t;
    int got_done;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req_if.req_valid    = 1'b0;
    req_if.req_op       = 1'b0;
    req_if.req_rule_idx = '0;
    req_if.req_value    = '0;
    req_if.req_mask     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_if.req_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_stall", search_stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rv", rule_valid, 0);

    run_update(1'b0, 6'd3, 32'hC0A80100, 32'hFFFFFF00, 0,
               48'h8);
    run_update(1'b1, 6'd3, 32'hC0A80100, 32'hFFFFFF00, 1,
               48'h0);
    run_update(1'b0, 6'd0, 32'h12345678, 32'h0, 2, 48'h1);

    // out-of-range slot
    @(negedge clk);
    req_if.req_valid    = 1'b1;
    req_if.req_op       = 1'b0;
    req_if.req_rule_idx = 6'd50;
    req_if.req_mask     = 32'hFFFFFFFF;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    check("oor_done", done, 1);
    check("oor_err", err, 1);
    check("oor_wr_en", wr_en, 0);
    check("oor_stall", search_stall, 1);
    check("oor_ready", req_if.req_ready, 0);
    check("oor_rv", rule_valid, 48'h1);
    @(negedge clk);
    check("oor_done_off", done, 0);
    check("oor_err_off", err, 0);
    check("oor_ready_i", req_if.req_ready, 1);
    check("oor_stall_i", search_stall, 0);

    // back-to-back with valid held high
    @(negedge clk);
    req_if.req_valid    = 1'b1;
    req_if.req_op       = 1'b0;
    req_if.req_rule_idx = 6'd5;
    req_if.req_mask     = 32'h0;
    seen_t = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) begin
        check("b2b_first", wr_rule, 5);
        req_if.req_rule_idx = 6'd6;
      end
      if (t <= 17) check("b2b_ready_lo", req_if.req_ready, 0);
      if (t == 18) check("b2b_ready_hi", req_if.req_ready, 1);
      if (wr_en && wr_rule == 6'd6) begin
        seen_t = t;
        req_if.req_valid = 1'b0;
        break;
      end
    end
    check("b2b_accept_t", seen_t, 19);
    got_done = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        break;
      end
    end
    check("b2b_done", got_done, 1);
    check("b2b_rv", rule_valid, 48'h61);

    // reset during the 8th write cycle
    @(negedge clk);
    req_if.req_valid    = 1'b1;
    req_if.req_rule_idx = 6'd9;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_addr", wr_addr, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_wr_en", wr_en, 0);
    check("mid_stall", search_stall, 0);
    check("mid_rv", rule_valid, 0);
    check("mid_ready", req_if.req_ready, 1);
    check("mid_done", done, 0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("post_done", done, 0);
      check("post_wr_en", wr_en, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
